contador_mortes_rodada: RTL

//   Per-round death tally for the game core, generalised to N players.
//   - Accepts one death-flag vector per round (valid/ready).
//   - Masks out players already dead and counts new deaths through a 2-stage pipelined adder tree.
//   - Tracks the alive mask and alive total across rounds; flags end of game.
//   - Sits between the round-resolution logic and the game-control FSM.

---
 rtl/contador_mortes_rodada.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/contador_mortes_rodada.sv
// -----------------------------------------------------------------------------
// contador_mortes_rodada
//   Per-round death tally for the game core, for N_JOGADORES players.
//   Takes one death-flag vector per round through a valid/ready handshake.
//   Flags for players who are already dead are masked off. New deaths are
//   counted by a two-stage pipelined adder tree. The block keeps the alive
//   mask and the alive total across rounds and raises the game-over flag.
//
//   Optional feature macro: CONTA_LOBOS_EN
//     Adds the wolf-role mask input i_lobos, sampled on i_iniciar, and the
//     output o_lobos_vivos. It also swaps the game-over rule for the
//     wolves-vs-villagers rule.
//
// Ports
//   i_clock         rising-edge clock
//   i_reset_n       asynchronous, active-low reset
//   i_iniciar       new game: revive everyone, abort any round in flight
//   i_mortes        death flags for this round, bit i = player i
//   i_mortes_valid  i_mortes is valid this cycle
//   o_mortes_ready  block can accept a round (decode of the state register)
//   o_count_valid   one-cycle pulse: count/alive outputs were just updated
//   o_count_mortes  new deaths counted in the last completed round
//   o_vivos         alive mask, bit i = 1 while player i is alive
//   o_total_vivos   popcount of o_vivos
//   o_fim_jogo      game over (sticky until i_iniciar or reset)
//   i_lobos         (CONTA_LOBOS_EN) wolf-role mask
//   o_lobos_vivos   (CONTA_LOBOS_EN) number of wolves still alive
// -----------------------------------------------------------------------------
module contador_mortes_rodada #(
  parameter int unsigned N_JOGADORES = 5,
  localparam int unsigned W = $clog2(N_JOGADORES + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_iniciar,
  input  logic [N_JOGADORES-1:0] i_mortes,
  input  logic                   i_mortes_valid,
  output logic                   o_mortes_ready,
  output logic                   o_count_valid,
  output logic [W-1:0]           o_count_mortes,
  output logic [N_JOGADORES-1:0] o_vivos,
  output logic [W-1:0]           o_total_vivos,
`ifdef CONTA_LOBOS_EN
  input  logic [N_JOGADORES-1:0] i_lobos,
  output logic [W-1:0]           o_lobos_vivos,
`endif
  output logic                   o_fim_jogo
);

  // Split point of the adder tree: the low half is the bits below N_LO.
  localparam int unsigned N_LO = N_JOGADORES / 2;
  localparam logic [N_JOGADORES-1:0] MASCARA_LO =
    N_JOGADORES'((64'd1 << N_LO) - 64'd1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    MASCARA = 2'd1,
    SOMA    = 2'd2
  } estado_t;

  // Number of set bits in a player vector.
  function automatic logic [W-1:0] popcount(input logic [N_JOGADORES-1:0] v);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_JOGADORES); i++) begin
      c = c + W'(v[i]);
    end
    return c;
  endfunction

  estado_t                r_estado;
  logic [N_JOGADORES-1:0] r_efetivas;
  logic [W-1:0]           r_soma_lo;
  logic [W-1:0]           r_soma_hi;
  logic                   r_count_valid;
  logic [W-1:0]           r_count_mortes;
  logic [N_JOGADORES-1:0] r_vivos;
  logic [W-1:0]           r_total_vivos;
  logic                   r_fim_jogo;

  logic [W-1:0]           w_soma;
  logic [W-1:0]           w_total_novo;
  logic                   w_fim_regra;

`ifdef CONTA_LOBOS_EN
  logic [N_JOGADORES-1:0] r_lobos;
  logic [W-1:0]           r_lobos_vivos;
  logic [W-1:0]           r_soma_lobos;
  logic [W-1:0]           w_lobos_novo;
`endif

  // Final stage of the adder tree, plus the alive total after this round.
  // efetivas is a subset of vivos, so the subtraction cannot wrap.
  assign w_soma       = r_soma_lo + r_soma_hi;
  assign w_total_novo = r_total_vivos - w_soma;

`ifdef CONTA_LOBOS_EN
  // Game over when the wolves are gone or are at least as many as the others.
  assign w_lobos_novo = r_lobos_vivos - r_soma_lobos;
  assign w_fim_regra  = (w_lobos_novo == '0) ||
                        (w_lobos_novo >= (w_total_novo - w_lobos_novo));
`else
  // Game over when at most one player is left standing.
  assign w_fim_regra  = (w_total_novo <= W'(1));
`endif

  // Round FSM and all registered state. i_iniciar overrides everything.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_estado       <= OCIOSO;
      r_efetivas     <= '0;
      r_soma_lo      <= '0;
      r_soma_hi      <= '0;
      r_count_valid  <= 1'b0;
      r_count_mortes <= '0;
      r_vivos        <= '1;
      r_total_vivos  <= W'(N_JOGADORES);
      r_fim_jogo     <= 1'b0;
`ifdef CONTA_LOBOS_EN
      r_lobos        <= '0;
      r_lobos_vivos  <= '0;
      r_soma_lobos   <= '0;
`endif
    end else begin
      r_count_valid <= 1'b0;
      if (i_iniciar) begin
        // New game; any round in flight is dropped without a pulse.
        r_estado       <= OCIOSO;
        r_efetivas     <= '0;
        r_count_mortes <= '0;
        r_vivos        <= '1;
        r_total_vivos  <= W'(N_JOGADORES);
        r_fim_jogo     <= 1'b0;
`ifdef CONTA_LOBOS_EN
        r_lobos        <= i_lobos;
        r_lobos_vivos  <= popcount(i_lobos);
`endif
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (i_mortes_valid) begin
              r_efetivas <= i_mortes & r_vivos;
              r_estado   <= MASCARA;
            end
          end
          MASCARA: begin
            r_soma_lo    <= popcount(r_efetivas & MASCARA_LO);
            r_soma_hi    <= popcount(r_efetivas & ~MASCARA_LO);
`ifdef CONTA_LOBOS_EN
            r_soma_lobos <= popcount(r_efetivas & r_lobos);
`endif
            r_estado     <= SOMA;
          end
          SOMA: begin
            r_count_mortes <= w_soma;
            r_vivos        <= r_vivos & ~r_efetivas;
            r_total_vivos  <= w_total_novo;
            r_fim_jogo     <= r_fim_jogo | w_fim_regra;
`ifdef CONTA_LOBOS_EN
            r_lobos_vivos  <= w_lobos_novo;
`endif
            r_count_valid  <= 1'b1;
            r_estado       <= OCIOSO;
          end
          default: begin
            r_estado <= OCIOSO;
          end
        endcase
      end
    end
  end

  assign o_mortes_ready = (r_estado == OCIOSO);
  assign o_count_valid  = r_count_valid;
  assign o_count_mortes = r_count_mortes;
  assign o_vivos        = r_vivos;
  assign o_total_vivos  = r_total_vivos;
  assign o_fim_jogo     = r_fim_jogo;
`ifdef CONTA_LOBOS_EN
  assign o_lobos_vivos  = r_lobos_vivos;
`endif

endmodule
